// File: rtl/axis_hdr_pkg.sv
// Shared state encoding and keep-vector helpers for the AXI-Stream header inserter.
// Helpers operate on a 64-lane keep so one package serves every supported data width.
package axis_hdr_pkg;

    localparam int MAX_BYTES = 64;

    typedef logic [MAX_BYTES-1:0] keep_max_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    function automatic int popcount(input keep_max_t keep);
        int c;
        c = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (keep[i]) c++;
        end
        return c;
    endfunction

    function automatic keep_max_t lsb_mask(input int n);
        keep_max_t m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Top n lanes of an nbytes-wide keep; lane 0 on the wire is the highest bit.
    function automatic keep_max_t msb_mask(input int n, input int nbytes);
        keep_max_t m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes && i >= nbytes - n) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic is_lsb_contig(input keep_max_t keep);
        return (keep & (keep + keep_max_t'(1))) == '0;
    endfunction

    function automatic logic is_msb_contig(input keep_max_t keep, input int nbytes);
        return is_lsb_contig(~keep & lsb_mask(nbytes));
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Purpose: joins r residue bytes with k payload bytes; yields the head beat, leftover and total t.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when results are consumed.
module axis_byte_merge #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic [DATA_WD-1:0]     i_res,
    input  logic [BYTE_CNT_WD-1:0] i_r,
    input  logic [DATA_WD-1:0]     i_pay,
    input  logic [BYTE_CNT_WD-1:0] i_k,
    output logic [DATA_WD-1:0]     o_head,
    output logic [DATA_WD-1:0]     o_left,
    output logic [BYTE_CNT_WD:0]   o_t
);

    logic [DATA_WD-1:0]   w_pay;
    logic [DATA_WD-1:0]   w_left;
    logic [2*DATA_WD-1:0] w_cat;
    int                   w_lcnt;

    // Residue is held right-aligned, payload MSB-aligned; shifting the pair
    // left by the residue gap butts the two byte strings together.
    always_comb begin
        w_pay  = '0;
        o_left = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (i >= DATA_BYTE_WD - int'(i_k)) w_pay[8*i +: 8] = i_pay[8*i +: 8];
        end
        w_cat  = {i_res, w_pay} << (8 * (DATA_BYTE_WD - int'(i_r)));
        o_head = w_cat[2*DATA_WD-1 -: DATA_WD];
        o_t    = {1'b0, i_r} + {1'b0, i_k};
        w_lcnt = int'(o_t) - DATA_BYTE_WD;
        w_left = w_pay >> (8 * (DATA_BYTE_WD - int'(i_k)));
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (i < w_lcnt) o_left[8*i +: 8] = w_left[8*i +: 8];
        end
    end

endmodule

// File: rtl/axis_header_inserter.sv
// Purpose: prepends a 0..N byte header to each packet and repacks payload into full beats.
// Latency: one cycle from payload handshake to valid_out; one extra beat when bytes overflow.
// Backpressure: registered output held while stalled; ready_in follows the free output slot.
module axis_header_inserter
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    hdr_err
);

    state_t                  r_state, w_state_nxt;
    logic [DATA_WD-1:0]      r_res, w_res_nxt;
    logic [BYTE_CNT_WD-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_WD-1:0]      r_dat, w_dat_nxt;
    logic [DATA_BYTE_WD-1:0] r_keep, w_keep_nxt;
    logic                    r_vld, w_vld_nxt;
    logic                    r_last, w_last_nxt;
    logic                    r_err, w_err_nxt;

    logic [DATA_WD-1:0]      w_head, w_left;
    logic [BYTE_CNT_WD-1:0]  w_k;
    logic [BYTE_CNT_WD:0]    w_t;
    logic                    w_slot_free, w_hdr_hs, w_pay_hs;

    assign w_slot_free  = !r_vld || ready_out;
    assign ready_insert = rst_n && (r_state == IDLE);
    assign ready_in     = (r_state == STREAM) && w_slot_free;
    assign w_hdr_hs     = valid_insert && ready_insert;
    assign w_pay_hs     = valid_in && ready_in;
    assign w_k          = BYTE_CNT_WD'(popcount(keep_max_t'(keep_in)));

    axis_byte_merge #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_merge (
        .i_res  (r_res),
        .i_r    (r_cnt),
        .i_pay  (data_in),
        .i_k    (w_k),
        .o_head (w_head),
        .o_left (w_left),
        .o_t    (w_t)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = r_res;
        w_cnt_nxt   = r_cnt;
        w_vld_nxt   = r_vld && !ready_out;
        w_dat_nxt   = r_dat;
        w_keep_nxt  = r_keep;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (w_hdr_hs) begin
                    w_res_nxt = '0;
                    for (int i = 0; i < DATA_BYTE_WD; i++) begin
                        if (i < int'(byte_insert_cnt)) w_res_nxt[8*i +: 8] = data_insert[8*i +: 8];
                    end
                    w_cnt_nxt   = byte_insert_cnt;
                    w_state_nxt = STREAM;
                    if (!is_lsb_contig(keep_max_t'(keep_insert)) ||
                        popcount(keep_max_t'(keep_insert)) != int'(byte_insert_cnt))
                        w_err_nxt = 1'b1;
                end
            end
            STREAM: begin
                if (w_pay_hs) begin
                    w_vld_nxt = 1'b1;
                    w_dat_nxt = w_head;
                    if (last_in && int'(w_t) <= DATA_BYTE_WD) begin
                        w_keep_nxt  = DATA_BYTE_WD'(msb_mask(int'(w_t), DATA_BYTE_WD));
                        w_last_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_keep_nxt = '1;
                        w_last_nxt = 1'b0;
                        w_res_nxt  = w_left;
                        if (last_in) begin
                            w_cnt_nxt   = BYTE_CNT_WD'(int'(w_t) - DATA_BYTE_WD);
                            w_state_nxt = FLUSH;
                        end
                    end
                    if (last_in && (keep_in == '0 || !is_msb_contig(keep_max_t'(keep_in), DATA_BYTE_WD)))
                        w_err_nxt = 1'b1;
                end
            end
            FLUSH: begin
                if (w_slot_free) begin
                    w_vld_nxt   = 1'b1;
                    w_dat_nxt   = r_res << (8 * (DATA_BYTE_WD - int'(r_cnt)));
                    w_keep_nxt  = DATA_BYTE_WD'(msb_mask(int'(r_cnt), DATA_BYTE_WD));
                    w_last_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Disabled lanes always leave the block as zero bytes.
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (!w_keep_nxt[i]) w_dat_nxt[8*i +: 8] = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res  <= '0;
            r_cnt  <= '0;
            r_vld  <= 1'b0;
            r_dat  <= '0;
            r_keep <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_res  <= w_res_nxt;
            r_cnt  <= w_cnt_nxt;
            r_vld  <= w_vld_nxt;
            r_dat  <= w_dat_nxt;
            r_keep <= w_keep_nxt;
            r_last <= w_last_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign valid_out = r_vld;
    assign data_out  = r_dat;
    assign keep_out  = r_keep;
    assign last_out  = r_last;
    assign hdr_err   = r_err;

endmodule
